// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a small show-ahead read FIFO.
// The serial input is synchronised, sampled mid-bit by a divider counter, and
// every good byte is pushed into a circular buffer. Framing and overrun errors
// are kept as sticky flags until the CPU clears them.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 27000000,
    parameter int BIT_RATE   = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int DIV   = CLOCK_FREQ / BIT_RATE;
    localparam int CNT_W = $clog2(DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CW-1:0]    CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic             r_sync1;
    logic             r_rx_s;
    state_t           r_state;
    state_t           w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_n;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_n;
    logic             w_push;
    logic             w_ferr_set;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr_en;
    logic             w_ovr_set;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    // Receiver state, bit-timing counter, bit index and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
        end
    end

    // Next-state logic: half-bit to centre on the start bit, then full bits.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt + 1'b1;
        w_idx_n    = r_idx;
        w_shift_n  = r_shift;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (!r_rx_s) begin
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_n = '0;
                    w_idx_n = '0;
                    // A high level at mid start bit is a glitch, not a frame.
                    w_state_n = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_n   = '0;
                    w_shift_n = {r_rx_s, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_n = S_STOP;
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_n    = '0;
                    w_state_n  = S_IDLE;
                    w_push     = r_rx_s;
                    w_ferr_set = !r_rx_s;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_pop     = rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    // Circular buffer storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr_set) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rd_data   = r_mem[r_rd_ptr];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with DIV=16 and a 4-entry FIFO.
// Bytes expected to land in the FIFO are queued as frames are sent and are
// popped and compared when the bench reads the FIFO head.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .CLOCK_FREQ (16),
        .BIT_RATE   (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the head byte against the scoreboard, then pulse rd_en one cycle.
    task automatic pop_byte(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=pop expected=no_entry", tag);
        end else begin
            check(tag, {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Drive one 8N1 frame, 16 clocks per bit, starting on a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_stop);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop;
        if (pop_at_stop) begin
            repeat (10) @(negedge clk);
            pop_byte("t5_pop_at_stop");
            repeat (5) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_data", {24'h0, rd_data}, 32'h0);
        check("rst_empty", {31'h0, empty}, 32'h1);
        check("rst_full", {31'h0, full}, 32'h0);
        check("rst_count", {29'h0, count}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single good frame, then one pop.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t1_empty", {31'h0, empty}, 32'h0);
        check("t1_count", {29'h0, count}, 32'h1);
        pop_byte("t1_data");
        check("t1_empty_after_pop", {31'h0, empty}, 32'h1);
        check("t1_count_after_pop", {29'h0, count}, 32'h0);

        // 2: short low pulse is rejected as a glitch.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("t2_empty", {31'h0, empty}, 32'h1);
        check("t2_frame_err", {31'h0, frame_err}, 32'h0);
        check("t2_overrun", {31'h0, overrun}, 32'h0);

        // 3: bad stop bit sets frame_err; clr_err clears it.
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("t3_frame_err", {31'h0, frame_err}, 32'h1);
        check("t3_empty", {31'h0, empty}, 32'h1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("t3_frame_err_clr", {31'h0, frame_err}, 32'h0);

        // 4: five back-to-back frames into a 4-deep FIFO.
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back(8'(k));
            send_frame(8'(k), 1'b1, 1'b0);
        end
        repeat (4) @(negedge clk);
        check("t4_full", {31'h0, full}, 32'h1);
        check("t4_count", {29'h0, count}, 32'h4);
        check("t4_overrun", {31'h0, overrun}, 32'h1);
        for (int k = 0; k < 4; k++) pop_byte("t4_data");
        check("t4_empty", {31'h0, empty}, 32'h1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("t4_overrun_clr", {31'h0, overrun}, 32'h0);

        // 5: full FIFO with a pop on the stop-sample cycle accepts the new byte.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b0);
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, 1'b0);
        exp_q.push_back(8'h44);
        send_frame(8'h44, 1'b1, 1'b0);
        check("t5_full_before", {31'h0, full}, 32'h1);
        exp_q.push_back(8'h66);
        send_frame(8'h66, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("t5_count", {29'h0, count}, 32'h4);
        check("t5_overrun", {31'h0, overrun}, 32'h0);
        check("t5_full", {31'h0, full}, 32'h1);
        for (int k = 0; k < 4; k++) pop_byte("t5_data");
        check("t5_empty", {31'h0, empty}, 32'h1);

        // 6: async reset mid-frame with state to clear, then a clean frame.
        send_frame(8'h00, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("t6_pre_frame_err", {31'h0, frame_err}, 32'h1);
        check("t6_pre_count", {29'h0, count}, 32'h1);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = (i == 1) ? 1'b1 : 1'b0;
            repeat (16) @(negedge clk);
        end
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("t6_rst_rd_data", {24'h0, rd_data}, 32'h0);
        check("t6_rst_empty", {31'h0, empty}, 32'h1);
        check("t6_rst_count", {29'h0, count}, 32'h0);
        check("t6_rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("t6_rst_full", {31'h0, full}, 32'h0);
        @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("t6_no_push", {31'h0, empty}, 32'h1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t6_count", {29'h0, count}, 32'h1);
        pop_byte("t6_data");
        check("t6_empty", {31'h0, empty}, 32'h1);
        check("t6_frame_err", {31'h0, frame_err}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
